// File: rtl/dsram_ctrl.sv
// dsram_ctrl: data-SRAM access controller running AXI4-Lite read/write transactions for the LSU.
// Ports: clk/rst (async active-high); valid_i/ready_o request handshake with inst_type_i, lsu_op_i,
// araddr_i, roff_i, awaddr_i, wdata_i, wstrb_i; AR/R/AW/W/B AXI4-Lite master channels;
// valid_o/ready_i result handshake with load_data_o. Define DSRAM_CTRL_FAULT_EN to add fault_o
// (nonzero rresp/bresp reported with the result; faulting loads return 0).
// Encodings: inst_type LOAD=1 STORE=2; lsu_op LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8.
module dsram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  inst_type_i,
  input  logic [3:0]  lsu_op_i,
  input  logic [31:0] araddr_i,
  input  logic [31:0] roff_i,
  input  logic [31:0] awaddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [7:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        valid_o,
  input  logic        ready_i,
`ifdef DSRAM_CTRL_FAULT_EN
  output logic        fault_o,
`endif
  output logic [31:0] load_data_o
);
  localparam logic [2:0] INST_LOAD = 3'd1, INST_STORE = 3'd2;
  localparam logic [3:0] LSU_LB = 4'd1, LSU_LH = 4'd2, LSU_LW = 4'd3, LSU_LBU = 4'd4, LSU_LHU = 4'd5;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  roff_q, roff_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d, bready_q, bready_d, valid_q, valid_d, ready_q, ready_d;
  logic [31:0] sh, ld_ext;
  logic        rfault;
  logic        unused;
  assign unused = ^{roff_i[31:2], rresp_i, bresp_i};
  assign sh = rdata_i >> {roff_q, 3'b000};
  assign ld_ext = op_q == LSU_LB  ? {{24{sh[7]}}, sh[7:0]} :
                  op_q == LSU_LBU ? {24'b0, sh[7:0]} :
                  op_q == LSU_LH  ? {{16{sh[15]}}, sh[15:0]} :
                  op_q == LSU_LHU ? {16'b0, sh[15:0]} :
                  op_q == LSU_LW  ? sh : 32'b0;
`ifdef DSRAM_CTRL_FAULT_EN
  logic fault_q, fault_d;
  assign rfault = |rresp_i;
  assign fault_d = state_q == IDLE ? 1'b0 :
                   state_q == RD_DATA && rvalid_i ? |rresp_i :
                   state_q == WR_RESP && bvalid_i ? |bresp_i :
                   state_q == DONE && ready_i ? 1'b0 : fault_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) fault_q <= 1'b0;
    else fault_q <= fault_d;
  assign fault_o = fault_q;
`else
  assign rfault = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    roff_d    = roff_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ld_d      = ld_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (valid_i) begin
        op_d      = lsu_op_i;
        roff_d    = roff_i[1:0];
        araddr_d  = araddr_i;
        awaddr_d  = awaddr_i;
        wdata_d   = wdata_i << {awaddr_i[1:0], 3'b000};
        wstrb_d   = wstrb_i;
        ld_d      = 32'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = inst_type_i == INST_LOAD ? RD_ADDR : inst_type_i == INST_STORE ? WR : DONE;
      end
      RD_ADDR: state_d = arready_i ? RD_DATA : RD_ADDR;
      RD_DATA: if (rvalid_i) begin
        ld_d    = rfault ? 32'b0 : ld_ext;
        state_d = DONE;
      end
      WR: begin
        // each channel's handshake is remembered so the other may complete later
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        state_d   = aw_done_d && w_done_d ? WR_RESP : WR;
      end
      WR_RESP: state_d = bvalid_i ? DONE : WR_RESP;
      DONE:    state_d = ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    arvalid_d = state_d == RD_ADDR;
    rready_d  = state_d == RD_DATA;
    awvalid_d = state_d == WR && !aw_done_d;
    wvalid_d  = state_d == WR && !w_done_d;
    bready_d  = state_d == WR_RESP;
    valid_d   = state_d == DONE;
    ready_d   = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      roff_q    <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ld_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      roff_q    <= roff_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ld_q      <= ld_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end
  // ready_q resets to 1 so the request port opens as soon as reset releases
  assign ready_o     = ready_q & ~rst;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign awvalid_o   = awvalid_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign valid_o     = valid_q;
  assign araddr_o    = araddr_q;
  assign awaddr_o    = awaddr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign load_data_o = ld_q;
endmodule
